// File: rtl/multi_counter.sv
// Bank of CHANNELS independent WIDTH-bit up/down counters with load, limit, wrap/saturate and sticky overflow.
// Define CNT_SNAPSHOT_EN to add the snap strobe and the snap_cnt snapshot registers.
module multi_counter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned RST_VAL  = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS-1:0]          en,
  input  logic [CHANNELS-1:0]          up,
  input  logic [CHANNELS-1:0]          load,
  input  logic [CHANNELS*WIDTH-1:0]    load_val,
  input  logic [CHANNELS*WIDTH-1:0]    limit,
  input  logic [CHANNELS-1:0]          sat,
  input  logic [CHANNELS-1:0]          clr_ovf,
`ifdef CNT_SNAPSHOT_EN
  input  logic                         snap,
  output logic [CHANNELS*WIDTH-1:0]    snap_cnt,
`endif
  output logic [CHANNELS*WIDTH-1:0]    cnt,
  output logic [CHANNELS-1:0]          tc,
  output logic [CHANNELS-1:0]          ovf
);

  localparam int unsigned TOTAL_W = CHANNELS * WIDTH;

  logic [TOTAL_W-1:0]  cnt_nxt;
  logic [CHANNELS-1:0] tc_nxt;
  logic [CHANNELS-1:0] ovf_nxt;
  logic [WIDTH-1:0]    cur;
  logic [WIDTH-1:0]    lim;
  logic [WIDTH-1:0]    lv;
  logic [WIDTH-1:0]    nxt;
  logic                term;

  // Per-channel next state: load beats count; a terminal event drives tc and sets ovf.
  always_comb begin
    cnt_nxt = cnt;
    tc_nxt  = '0;
    ovf_nxt = ovf;
    cur     = '0;
    lim     = '0;
    lv      = '0;
    nxt     = '0;
    term    = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      cur  = cnt[i*WIDTH +: WIDTH];
      lim  = limit[i*WIDTH +: WIDTH];
      lv   = load_val[i*WIDTH +: WIDTH];
      nxt  = cur;
      term = 1'b0;
      if (load[i]) begin
        nxt = (lv > lim) ? lim : lv;
      end else if (en[i]) begin
        if (up[i]) begin
          if (cur >= lim) begin
            term = 1'b1;
            nxt  = sat[i] ? lim : '0;
          end else begin
            nxt = cur + WIDTH'(1);
          end
        end else begin
          // A count left above a lowered limit is pulled back without a terminal event.
          if (cur > lim) begin
            nxt = lim;
          end else if (cur == '0) begin
            term = 1'b1;
            nxt  = sat[i] ? '0 : lim;
          end else begin
            nxt = cur - WIDTH'(1);
          end
        end
      end
      cnt_nxt[i*WIDTH +: WIDTH] = nxt;
      tc_nxt[i]                 = term;
      ovf_nxt[i]                = term | (ovf[i] & ~clr_ovf[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= {CHANNELS{WIDTH'(RST_VAL)}};
      tc  <= '0;
      ovf <= '0;
    end else begin
      cnt <= cnt_nxt;
      tc  <= tc_nxt;
      ovf <= ovf_nxt;
    end
  end

`ifdef CNT_SNAPSHOT_EN
  // Snapshot captures the post-edge counter value so it matches cnt after the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_cnt <= '0;
    end else if (snap) begin
      snap_cnt <= cnt_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_multi_counter.sv
// Randomised self-checking bench for multi_counter against an arithmetic reference model.
module tb_multi_counter;
  localparam int unsigned W  = 8;
  localparam int unsigned N  = 2;
  localparam int unsigned RV = 0;
  localparam int          MAXV = (1 << W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     en, up, load, sat, clr_ovf;
  logic [N*W-1:0]   load_val, limit;
  logic [N*W-1:0]   cnt;
  logic [N-1:0]     tc, ovf;
`ifdef CNT_SNAPSHOT_EN
  logic             snap;
  logic [N*W-1:0]   snap_cnt;
`endif

  int checks = 0;
  int errors = 0;

  int m_cnt  [N];
  int m_tc   [N];
  int m_ovf  [N];
  int m_snap [N];

  multi_counter #(.WIDTH(W), .CHANNELS(N), .RST_VAL(RV)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .limit    (limit),
    .sat      (sat),
    .clr_ovf  (clr_ovf),
`ifdef CNT_SNAPSHOT_EN
    .snap     (snap),
    .snap_cnt (snap_cnt),
`endif
    .cnt      (cnt),
    .tc       (tc),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: counter rules evaluated with plain integer arithmetic.
  task automatic model_step();
    int c, l, lv, t;
    for (int ch = 0; ch < N; ch++) begin
      c  = m_cnt[ch];
      l  = int'(limit[ch*W +: W]);
      lv = int'(load_val[ch*W +: W]);
      t  = 0;
      if (rst) begin
        m_cnt[ch]  = RV;
        m_tc[ch]   = 0;
        m_ovf[ch]  = 0;
        m_snap[ch] = 0;
      end else begin
        if (load[ch]) c = (lv < l) ? lv : l;
        else if (en[ch]) begin
          if (up[ch]) begin
            if (c < l) c = c + 1;
            else begin t = 1; c = sat[ch] ? l : 0; end
          end else begin
            if (c > l) c = l;
            else if (c == 0) begin t = 1; c = sat[ch] ? 0 : l; end
            else c = c - 1;
          end
        end
        m_cnt[ch] = c;
        m_tc[ch]  = t;
        if (t != 0) m_ovf[ch] = 1;
        else if (clr_ovf[ch]) m_ovf[ch] = 0;
`ifdef CNT_SNAPSHOT_EN
        if (snap) m_snap[ch] = c;
`endif
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    for (int ch = 0; ch < N; ch++) begin
      check($sformatf("cnt%0d", ch), 32'(cnt[ch*W +: W]), 32'(m_cnt[ch]));
      check($sformatf("tc%0d", ch),  32'(tc[ch]),  32'(m_tc[ch]));
      check($sformatf("ovf%0d", ch), 32'(ovf[ch]), 32'(m_ovf[ch]));
`ifdef CNT_SNAPSHOT_EN
      check($sformatf("snap%0d", ch), 32'(snap_cnt[ch*W +: W]), 32'(m_snap[ch]));
`endif
    end
  endtask

  task automatic idle_inputs();
    en = '0; up = '0; load = '0; sat = '0; clr_ovf = '0;
    load_val = '0; limit = {N{W'(MAXV)}};
`ifdef CNT_SNAPSHOT_EN
    snap = 1'b0;
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic randomize_inputs();
    for (int ch = 0; ch < N; ch++) begin
      en[ch]      = ($urandom_range(0, 3) != 0);
      up[ch]      = $urandom_range(0, 1) != 0;
      load[ch]    = ($urandom_range(0, 7) == 0);
      sat[ch]     = ($urandom_range(0, 3) == 0) ? ~sat[ch] : sat[ch];
      clr_ovf[ch] = ($urandom_range(0, 7) == 0);
      load_val[ch*W +: W] = W'($urandom_range(0, MAXV));
      if ($urandom_range(0, 15) == 0)
        limit[ch*W +: W] = ($urandom_range(0, 1) != 0) ? W'($urandom_range(0, 7))
                                                        : W'($urandom_range(0, MAXV));
    end
    rst = ($urandom_range(0, 63) == 0);
`ifdef CNT_SNAPSHOT_EN
    snap = ($urandom_range(0, 3) == 0);
`endif
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    for (int ch = 0; ch < N; ch++) begin
      m_cnt[ch] = RV; m_tc[ch] = 0; m_ovf[ch] = 0; m_snap[ch] = 0;
    end

    // Reset then count up on both channels.
    do_reset();
    check("rst_cnt", 32'(cnt), 32'(0));
    en = 2'b11; up = 2'b11;
    for (int k = 0; k < 3; k++) cycle();
    check("up3_cnt", 32'(cnt), 32'({8'd3, 8'd3}));
    check("up3_tc", 32'(tc), 32'(0));

    // Wrap up on channel 0 with limit 5.
    en = '0; limit[0 +: W] = W'(5); load = 2'b01; load_val[0 +: W] = W'(4);
    cycle();
    load = '0; en = 2'b01; up = 2'b01;
    cycle(); check("wrap_a", 32'(cnt[0 +: W]), 32'(5)); check("wrap_a_tc", 32'(tc[0]), 32'(0));
    cycle(); check("wrap_b", 32'(cnt[0 +: W]), 32'(0)); check("wrap_b_tc", 32'(tc[0]), 32'(1));
    cycle(); check("wrap_c", 32'(cnt[0 +: W]), 32'(1)); check("wrap_c_ovf", 32'(ovf[0]), 32'(1));

    // Saturate down on channel 1 with limit 9.
    en = '0; sat[1] = 1'b1; limit[W +: W] = W'(9); load = 2'b10; load_val[W +: W] = W'(1);
    cycle();
    load = '0; en = 2'b10; up = 2'b00;
    cycle(); check("satd_a_tc", 32'(tc[1]), 32'(0));
    cycle(); check("satd_b_tc", 32'(tc[1]), 32'(1));
    cycle(); check("satd_c", 32'(cnt[W +: W]), 32'(0)); check("satd_c_ovf", 32'(ovf[1]), 32'(1));

    // Load clamp beats enable; lowered limit forces a wrap.
    sat = '0; limit[0 +: W] = W'(10); load = 2'b01; load_val[0 +: W] = W'(200); en = 2'b01; up = 2'b01;
    cycle(); check("clamp", 32'(cnt[0 +: W]), 32'(10)); check("clamp_tc", 32'(tc[0]), 32'(0));
    load = '0; limit[0 +: W] = W'(3);
    cycle(); check("lower", 32'(cnt[0 +: W]), 32'(0)); check("lower_tc", 32'(tc[0]), 32'(1));

    // Set beats clear in the same cycle, then clear alone, then mid-count reset.
    limit[0 +: W] = W'(0); clr_ovf = 2'b01;
    cycle(); check("race_ovf", 32'(ovf[0]), 32'(1));
    en = '0;
    cycle(); check("clr_ovf", 32'(ovf[0]), 32'(0));
    clr_ovf = '0; limit[0 +: W] = W'(MAXV); load = 2'b01; load_val[0 +: W] = W'(7);
    cycle();
    load = '0; en = 2'b01; rst = 1'b1;
    cycle(); check("mid_rst", 32'(cnt[0 +: W]), 32'(RV)); check("mid_rst_tc", 32'(tc), 32'(0));
    rst = 1'b0;

`ifdef CNT_SNAPSHOT_EN
    // Snapshot taken on the edge producing 4,4 then held.
    idle_inputs();
    do_reset();
    en = 2'b11; up = 2'b11;
    for (int k = 0; k < 3; k++) cycle();
    snap = 1'b1;
    cycle(); check("snap_take", 32'(snap_cnt), 32'({8'd4, 8'd4}));
    snap = 1'b0;
    cycle(); cycle(); check("snap_hold", 32'(snap_cnt), 32'({8'd4, 8'd4}));
`endif

    // Randomised traffic against the model.
    idle_inputs();
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      randomize_inputs();
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_counter.md
Name: multi_counter

Overview:
- Parametrised bank of CHANNELS independent WIDTH-bit counters.
- Each channel has per-channel enable, direction, parallel load, programmable terminal limit, and wrap/saturate mode.
- Generalises the team's fixed 8-bit up-counter with synchronous reset.
- Used as the shared event/timer counter block feeding status and interrupt logic.

Parameters:
- WIDTH, 8: counter width in bits, range 2..32.
- CHANNELS, 2: number of independent counters, range 1..16.
- RST_VAL, 0: value every counter takes on reset; must be <= 2^WIDTH-1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  CHANNELS  per-channel count enable.
- up  input  CHANNELS  per-channel direction: 1 = increment, 0 = decrement.
- load  input  CHANNELS  per-channel parallel load strobe.
- load_val  input  CHANNELS*WIDTH  load values; channel i uses bits [i*WIDTH +: WIDTH].
- limit  input  CHANNELS*WIDTH  per-channel terminal value (inclusive maximum); same packing as load_val.
- sat  input  CHANNELS  per-channel mode: 1 = saturate, 0 = wrap.
- clr_ovf  input  CHANNELS  per-channel clear for the sticky overflow flag.
- cnt  output  CHANNELS*WIDTH  registered counter values; same packing as load_val.
- tc  output  CHANNELS  one-cycle pulse on a terminal event.
- ovf  output  CHANNELS  sticky terminal-event flag.
- snap  input  1  snapshot strobe (only with CNT_SNAPSHOT_EN).
- snap_cnt  output  CHANNELS*WIDTH  snapshot copy (only with CNT_SNAPSHOT_EN).

Behaviour:
- Reset values: cnt = RST_VAL on every channel; tc = 0; ovf = 0; snap_cnt = 0.
- Latency: all outputs are registered. Inputs sampled at edge N are reflected on the outputs after edge N.
- Per-channel update priority: rst > load > en. With en = 0 and load = 0, cnt holds.
- Load: cnt <= min(load_val, limit). Out-of-range loads are clamped. Load never asserts tc and never sets ovf.
- Count up, cnt < limit: cnt <= cnt+1.
- Count up, cnt >= limit (covers a limit lowered below the current count):
  - wrap mode: cnt <= 0.
  - saturate mode: cnt <= limit.
  - Both modes: tc = 1 for one cycle; ovf set.
- Count down, cnt > 0 and cnt <= limit: cnt <= cnt-1.
- Count down, cnt > limit: cnt <= limit. This is not a terminal event.
- Count down, cnt == 0:
  - wrap mode: cnt <= limit.
  - saturate mode: cnt <= 0.
  - Both modes: tc pulse; ovf set.
- Saturate mode, held at a boundary: tc pulses on every enabled cycle in which the boundary step is attempted.
- Arithmetic: no carry beyond WIDTH. limit = 0 means every enabled step is a terminal event and cnt stays 0.
- tc is 0 in any cycle without a terminal event, including load, hold and reset cycles.
- ovf: set by a terminal event, cleared by clr_ovf. If a terminal event and clr_ovf occur in the same cycle, set wins.
- Mid-operation reset: rst overrides load, en and clr_ovf on that edge. Operation resumes normally from RST_VAL on the next edge.
- Channel independence: channels share no state. Simultaneous events on different channels are all honoured in the same cycle.

Optional Feature:
- Macro: CNT_SNAPSHOT_EN.
- Defined:
  - Ports snap and snap_cnt exist.
  - On an edge with snap = 1, snap_cnt <= the next-state value of cnt for all channels, so the snapshot equals cnt as seen after the same edge.
  - Otherwise snap_cnt holds.
  - rst clears snap_cnt to 0 and has priority over snap.
- Undefined: snap and snap_cnt are absent and no snapshot registers are inferred.

Test Plan:
1. Reset, then count up. WIDTH=8, CHANNELS=2, rst held 2 cycles, then en=2'b11, up=2'b11, limit=255 on both channels -> cnt = 0,0 after reset; after 3 edges cnt = 3,3; tc = 0 throughout.
2. Wrap up. Ch0 limit=5, sat=0, loaded 4, then enabled up for 3 edges -> cnt0 = 5, 0, 1; tc0 pulses on the edge producing 0; ovf0 = 1 and stays 1.
3. Saturate down. Ch1 sat=1, limit=9, load 1, then enabled down for 3 edges -> cnt1 = 0, 0, 0; tc1 high on the 2nd and 3rd edges; ovf1 = 1.
4. Load clamp and priority. Ch0 limit=10, load=1 with load_val=200 and en=1 in the same cycle -> cnt0 = 10; tc0 = 0. Then limit=3 with up enabled -> cnt0 = 0; tc0 = 1.
5. ovf clear race. Terminal event and clr_ovf=1 in the same cycle -> ovf = 1. clr_ovf alone on the next cycle -> ovf = 0. rst asserted mid-count at cnt=7 -> cnt = RST_VAL next edge; ovf = 0; tc = 0.
6. Snapshot (CNT_SNAPSHOT_EN defined). Both channels counting up from 0, snap pulsed on the edge producing cnt = 4,4 -> snap_cnt = 4,4 and holds while cnt keeps advancing.
